// File: rtl/coeff_fetch_master_if.sv
// coeff_fetch_master_if
//   Bundles the two handshaked sides of the coefficient fetcher:
//   - Avalon-MM read channel to the 8-bit coefficient memory
//     (avm_address, avm_read, avm_waitrequest, avm_readdata, avm_readdatavalid)
//   - valid/ready coefficient stream to the register file
//     (coeff_data, coeff_index, coeff_valid, coeff_ready)
//   modport master : the fetcher itself.
//   modport slave  : the environment, i.e. the memory plus the stream consumer.
interface coeff_fetch_master_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;
    logic [DATA_W-1:0] coeff_data;
    logic [7:0]        coeff_index;
    logic              coeff_valid;
    logic              coeff_ready;

    modport master (
        output avm_address, avm_read,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid,
        output coeff_data, coeff_index, coeff_valid,
        input  coeff_ready
    );

    modport slave (
        input  avm_address, avm_read,
        output avm_waitrequest, avm_readdata, avm_readdatavalid,
        input  coeff_data, coeff_index, coeff_valid,
        output coeff_ready
    );
endinterface

// File: rtl/coeff_fetch_master.sv
// coeff_fetch_master
//   Avalon-MM read master that fetches NUM_COEFFS bytes of one layer's
//   convolution coefficients and streams them, with their index, to the
//   coefficient register file. Reads are pipelined single-beat; the number of
//   reads in flight plus bytes buffered never exceeds MAX_PENDING, which is
//   also the depth of the return FIFO, so the FIFO can never overflow.
//
// Ports
//   clk, reset   : clock, asynchronous active-high reset
//   get_coeffs   : one-cycle start pulse, layer sampled with it
//   busy / done  : fetch in progress / one-cycle completion pulse
//   bus (master) : Avalon read channel + coefficient stream
//   checksum     : 16-bit sum of popped bytes (only with COEFF_FETCH_CHECKSUM_EN)
//
// Optional feature macro: COEFF_FETCH_CHECKSUM_EN
module coeff_fetch_master #(
    parameter int                ADDR_W      = 12,
    parameter int                DATA_W      = 8,
    parameter int                NUM_COEFFS  = 9,
    parameter logic [ADDR_W-1:0] COEFF_BASE  = 'h040,
    parameter int                LAYER_SPAN  = 16,
    parameter int                MAX_PENDING = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 get_coeffs,
    input  logic [1:0]           layer,
    output logic                 busy,
    output logic                 done,
    coeff_fetch_master_if.master bus
`ifdef COEFF_FETCH_CHECKSUM_EN
    ,
    output logic [15:0]          checksum
`endif
);

    localparam int              PTR_W  = $clog2(MAX_PENDING);
    localparam int              CNT_W  = $clog2(MAX_PENDING + 1);
    localparam logic [7:0]      N_LAST = 8'(NUM_COEFFS);
    localparam logic [CNT_W:0]  CREDIT = (CNT_W + 1)'(MAX_PENDING);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(MAX_PENDING);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [1:0]        layer_q;
    logic [7:0]        issue_cnt, rsp_cnt, out_cnt;
    logic [CNT_W-1:0]  in_flight, fifo_count;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [DATA_W-1:0] fifo_mem [MAX_PENDING];
    logic [CNT_W:0]    occupancy;
    logic [ADDR_W-1:0] layer_base;
    logic              start, issue_ok, rd_acc, push, pop, fifo_nempty;

    // Handshake decode
    assign start       = (state == S_IDLE) && get_coeffs;
    assign occupancy   = {1'b0, in_flight} + {1'b0, fifo_count};
    // Issue only while a credit remains: outstanding reads + buffered bytes
    // must stay below the FIFO depth so every response has a slot waiting.
    assign issue_ok    = (state == S_ISSUE) && (issue_cnt < N_LAST) && (occupancy < CREDIT);
    assign rd_acc      = issue_ok && !bus.avm_waitrequest;
    // Responses with nothing outstanding (e.g. left over from before a reset)
    // are dropped.
    assign push        = bus.avm_readdatavalid && (in_flight != '0) && (rsp_cnt < N_LAST);
    assign fifo_nempty = (fifo_count != '0);
    assign pop         = fifo_nempty && bus.coeff_ready;

    // Address arithmetic wraps naturally at ADDR_W bits. The counter only
    // moves on acceptance, so the address is stable through waitrequest.
    assign layer_base      = COEFF_BASE + ADDR_W'(layer_q) * ADDR_W'(LAYER_SPAN);
    assign bus.avm_read    = issue_ok;
    assign bus.avm_address = (state == S_ISSUE) ? layer_base + ADDR_W'(issue_cnt) : '0;

    assign bus.coeff_valid = fifo_nempty;
    assign bus.coeff_data  = fifo_nempty ? fifo_mem[rd_ptr] : '0;
    assign bus.coeff_index = out_cnt;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next state and status outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE:  if (get_coeffs) state_nxt = S_ISSUE;
            S_ISSUE: begin
                busy = 1'b1;
                if (issue_cnt == N_LAST) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (out_cnt == N_LAST) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Counters and FIFO pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            layer_q    <= '0;
            issue_cnt  <= '0;
            rsp_cnt    <= '0;
            out_cnt    <= '0;
            in_flight  <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            if (start) begin
                layer_q   <= layer;
                issue_cnt <= '0;
                rsp_cnt   <= '0;
                out_cnt   <= '0;
            end else begin
                if (rd_acc) issue_cnt <= issue_cnt + 8'd1;
                if (push)   rsp_cnt   <= rsp_cnt + 8'd1;
                if (pop)    out_cnt   <= out_cnt + 8'd1;
            end

            unique case ({rd_acc, push})
                2'b10:   in_flight <= in_flight + CNT_W'(1);
                2'b01:   in_flight <= in_flight - CNT_W'(1);
                default: ;
            endcase

            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: ;
            endcase

            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // FIFO storage; contents are don't-care until written, output is gated
    // by coeff_valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.avm_readdata;
    end

`ifdef COEFF_FETCH_CHECKSUM_EN
    // Running sum of consumed bytes; final once DONE is reached since the
    // last pop is what moves the FSM out of DRAIN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      checksum <= '0;
        else if (start) checksum <= '0;
        else if (pop)   checksum <= checksum + 16'(bus.coeff_data);
    end
`endif

    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && (fifo_count == FULL)));

endmodule

// File: tb/tb_coeff_fetch_master.sv
// tb_coeff_fetch_master
//   Scoreboard bench for coeff_fetch_master. The start stimulus pushes the
//   expected read addresses and expected stream beats; a memory-slave process
//   and a stream monitor pop and compare independently. Slave latency,
//   waitrequest and consumer ready are randomised per fetch.
module tb_coeff_fetch_master;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam int N      = 9;
    localparam int MAXP   = 4;
    localparam int BASE   = 'h040;
    localparam int SPAN   = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       get_coeffs;
    logic [1:0] layer;
    logic       busy;
    logic       done;
`ifdef COEFF_FETCH_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    coeff_fetch_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    coeff_fetch_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_COEFFS(N),
        .COEFF_BASE(ADDR_W'(BASE)), .LAYER_SPAN(SPAN), .MAX_PENDING(MAXP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .get_coeffs(get_coeffs),
        .layer(layer),
        .busy(busy),
        .done(done),
        .bus(bus.master)
`ifdef COEFF_FETCH_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] idx; logic [7:0] data; } coeff_t;
    typedef struct { int due; logic [7:0] data; } rsp_t;

    int checks = 0;
    int failures = 0;
    coeff_t            exp_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    rsp_t              rsp_q[$];
    int                run_log[$];
    int  cyc = 0, last_due = 0, rd_cnt = 0, done_cnt = 0, pops = 0;
    int  done_base = 0, rd_base = 0, exp_sum = 0;
    int  stall_left = 0, lat_min = 1, lat_max = 1, rdy_mode = 0;
    bit  rand_stall = 0;
    logic [7:0] key = 8'h00;

    // Memory contents seen by the fetcher: low address byte, optionally scrambled.
    function automatic logic [7:0] mem_byte(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ key;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- memory slave ----------------
    logic              prev_stall = 1'b0;
    logic [ADDR_W-1:0] prev_addr;
    int                run = 0;

    always @(negedge clk) begin : slave_p
        logic w;
        rsp_t r;
        int   due;
        cyc++;
        if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
            bus.avm_readdatavalid = 1'b1;
            bus.avm_readdata      = rsp_q[0].data;
            void'(rsp_q.pop_front());
        end else begin
            bus.avm_readdatavalid = 1'b0;
            bus.avm_readdata      = 8'($urandom);
        end
        if (reset) begin
            exp_addr_q.delete();
            prev_stall = 1'b0;
            run = 0;
            bus.avm_waitrequest = 1'b0;
        end else begin
            if (bus.avm_read && stall_left > 0) begin
                w = 1'b1;
                stall_left--;
            end else begin
                w = rand_stall && ($urandom_range(0, 3) == 0);
            end
            bus.avm_waitrequest = w;
            if (prev_stall) begin
                check("read_held_in_stall", 32'(bus.avm_read), 32'(1));
                check("addr_held_in_stall", 32'(bus.avm_address), 32'(prev_addr));
            end
            if (bus.avm_read) begin
                run++;
                if (!w) begin
                    checks++;
                    if (exp_addr_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_read: got addr 0x%0h, expected no read", bus.avm_address);
                    end else if (bus.avm_address !== exp_addr_q[0]) begin
                        failures++;
                        $display("FAIL read_addr: got 0x%0h, expected 0x%0h", bus.avm_address, exp_addr_q[0]);
                        void'(exp_addr_q.pop_front());
                    end else begin
                        void'(exp_addr_q.pop_front());
                    end
                    due = cyc + $urandom_range(lat_min, lat_max);
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    r.due  = due;
                    r.data = mem_byte(bus.avm_address);
                    rsp_q.push_back(r);
                    rd_cnt++;
                    run_log.push_back(run);
                    run = 0;
                end
            end
            prev_stall = bus.avm_read && w;
            prev_addr  = bus.avm_address;
        end
    end

    // ---------------- consumer ready ----------------
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.coeff_ready = 1'b1;
            1:       bus.coeff_ready = 1'($urandom_range(0, 1));
            default: bus.coeff_ready = 1'b0;
        endcase
    end

    // ---------------- stream monitor ----------------
    logic       hold_v = 1'b0;
    logic [7:0] hold_d, hold_i;

    always @(negedge clk) begin : mon_p
        coeff_t e;
        if (reset) begin
            exp_q.delete();
            hold_v = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (hold_v) begin
                check("hold_valid", 32'(bus.coeff_valid), 32'(1));
                check("hold_data", 32'(bus.coeff_data), 32'(hold_d));
                check("hold_index", 32'(bus.coeff_index), 32'(hold_i));
            end
            if (bus.coeff_valid && bus.coeff_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pop: got index 0x%0h data 0x%0h, expected no output",
                             bus.coeff_index, bus.coeff_data);
                end else begin
                    e = exp_q.pop_front();
                    check("coeff_index", 32'(bus.coeff_index), 32'(e.idx));
                    check("coeff_data", 32'(bus.coeff_data), 32'(e.data));
                end
            end
            hold_v = bus.coeff_valid && !bus.coeff_ready;
            hold_d = bus.coeff_data;
            hold_i = bus.coeff_index;
        end
    end

    // ---------------- stimulus ----------------
    // Reference: layer L, coefficient i lives at (BASE + L*SPAN + i) mod 2^ADDR_W.
    task automatic push_expect(input logic [1:0] l);
        coeff_t e;
        logic [ADDR_W-1:0] a;
        exp_sum   = 0;
        done_base = done_cnt;
        rd_base   = rd_cnt;
        for (int i = 0; i < N; i++) begin
            a = ADDR_W'(BASE + int'(l) * SPAN + i);
            exp_addr_q.push_back(a);
            e.idx  = 8'(i);
            e.data = mem_byte(a);
            exp_q.push_back(e);
            exp_sum += int'(e.data);
        end
    endtask

    task automatic start_fetch(input logic [1:0] l);
        @(posedge clk); #1;
        get_coeffs = 1'b1;
        layer      = l;
        push_expect(l);
        @(posedge clk); #1;
        get_coeffs = 1'b0;
        layer      = 2'($urandom);
    endtask

    // Returns at the negedge inside the done cycle.
    task automatic wait_done(input string name);
        int n;
        n = 1;
        @(negedge clk);
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_timeout: done not seen, expected within 2000 cycles", name);
        end
`ifdef COEFF_FETCH_CHECKSUM_EN
        else check({name, "_checksum"}, 32'(checksum), 32'(exp_sum & 'hffff));
`endif
    endtask

    task automatic post_done(input string name);
        @(negedge clk);
        check({name, "_busy_after"}, 32'(busy), 32'(0));
        check({name, "_done_low"}, 32'(done), 32'(0));
        repeat (3) @(negedge clk);
        check({name, "_done_count"}, 32'(done_cnt - done_base), 32'(1));
        check({name, "_beats_left"}, 32'(exp_q.size()), 32'(0));
        check({name, "_reads_left"}, 32'(exp_addr_q.size()), 32'(0));
`ifdef COEFF_FETCH_CHECKSUM_EN
        check({name, "_checksum_stable"}, 32'(checksum), 32'(exp_sum & 'hffff));
`endif
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, 32'(busy), 32'(0));
        check({name, "_done"}, 32'(done), 32'(0));
        check({name, "_avm_read"}, 32'(bus.avm_read), 32'(0));
        check({name, "_avm_address"}, 32'(bus.avm_address), 32'(0));
        check({name, "_coeff_valid"}, 32'(bus.coeff_valid), 32'(0));
        check({name, "_coeff_data"}, 32'(bus.coeff_data), 32'(0));
        check({name, "_coeff_index"}, 32'(bus.coeff_index), 32'(0));
`ifdef COEFF_FETCH_CHECKSUM_EN
        check({name, "_checksum"}, 32'(checksum), 32'(0));
`endif
    endtask

    initial begin : watchdog
        #400000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin : stim
        int n;
        int pbase;
        bit seen;
        reset      = 1'b1;
        get_coeffs = 1'b0;
        layer      = 2'd0;
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Layer 0, best case: latency to first beat, in-order stream.
        start_fetch(2'd0);
        check("busy_after_start", 32'(busy), 32'(1));
        n = 0;
        while (!bus.coeff_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("first_valid_latency", 32'(n), 32'(3));
        wait_done("layer0");
        post_done("layer0");

        // Layer 2: addresses 0x060..0x068, index restarts at 0.
        start_fetch(2'd2);
        wait_done("layer2");
        post_done("layer2");

        // Consumer stalled: credits cap outstanding+buffered at MAXP.
        rdy_mode = 2;
        start_fetch(2'd0);
        repeat (20) @(negedge clk);
        check("reads_when_blocked", 32'(rd_cnt - rd_base), 32'(MAXP));
        check("read_low_when_full", 32'(bus.avm_read), 32'(0));
        rdy_mode = 0;
        wait_done("blocked");
        post_done("blocked");

        // Three waitrequest cycles on the first read.
        stall_left = 3;
        start_fetch(2'd0);
        wait_done("stall");
        post_done("stall");
        check("first_read_hold_cycles", 32'(run_log[rd_base]), 32'(4));

        // Restart attempts mid-fetch and in DONE are ignored; IDLE one is taken.
        start_fetch(2'd0);
        repeat (4) @(posedge clk);
        #1;
        get_coeffs = 1'b1;
        layer      = 2'd3;
        @(posedge clk); #1;
        get_coeffs = 1'b0;
        wait_done("ignore_mid");
        get_coeffs = 1'b1;
        layer      = 2'd1;
        @(posedge clk); #1;
        check("done_cycle_start_ignored", 32'(busy), 32'(0));
        check("ignore_mid_beats_left", 32'(exp_q.size()), 32'(0));
        check("ignore_mid_done_count", 32'(done_cnt - done_base), 32'(1));
        push_expect(2'd1);
        @(posedge clk); #1;
        get_coeffs = 1'b0;
        check("idle_start_accepted", 32'(busy), 32'(1));
        wait_done("restart");
        post_done("restart");

        // Reset after 5 pops with slow responses still outstanding.
        lat_min = 4;
        lat_max = 4;
        pbase   = pops;
        start_fetch(2'd0);
        n = 0;
        while (pops - pbase < 5 && n < 300) begin
            @(posedge clk);
            n++;
        end
        check("pops_before_reset", 32'(pops - pbase >= 5), 32'(1));
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        n     = 0;
        while ((rsp_q.size() != 0 || n < 4) && n < 50) begin
            @(negedge clk);
            if (bus.coeff_valid || busy) seen = 1'b1;
            n++;
        end
        check("stray_response_dropped", 32'(seen), 32'(0));
        lat_min = 1;
        lat_max = 1;
        start_fetch(2'd2);
        wait_done("after_reset");
        post_done("after_reset");

        // Randomised fetches.
        for (int t = 0; t < 8; t++) begin
            key        = 8'($urandom);
            lat_min    = 1;
            lat_max    = $urandom_range(1, 4);
            rand_stall = 1'b1;
            rdy_mode   = 1;
            start_fetch(2'($urandom));
            wait_done("random");
            post_done("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/coeff_fetch_master.md
Name: coeff_fetch_master

Overview:
- Avalon-MM read master that fetches one layer's convolution coefficients from the 8-bit coefficient memory slave.
- Started by a get_coeffs pulse carrying a layer number.
- Issues pipelined single-beat reads and buffers returned bytes in a small FIFO.
- Presents bytes with their index on a valid/ready stream to the coefficient register file downstream.

Parameters:
- ADDR_W, 12, Avalon address width (byte addresses).
- DATA_W, 8, Avalon read data width and coefficient width.
- NUM_COEFFS, 9, coefficients fetched per layer (1..255).
- COEFF_BASE, 12'h040, byte address of layer 0 coefficient 0.
- LAYER_SPAN, 16, address stride between layers (must be >= NUM_COEFFS).
- MAX_PENDING, 4, maximum reads in flight plus buffered; also FIFO depth (power of two, 2..16).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- get_coeffs  in  1  one-cycle start pulse.
- layer  in  2  layer select, sampled with get_coeffs.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last coefficient is consumed.
- avm_address  out  ADDR_W  read address.
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  DATA_W  returned data.
- avm_readdatavalid  in  1  returned data valid.
- coeff_data  out  DATA_W  coefficient byte.
- coeff_index  out  8  index of coeff_data, 0..NUM_COEFFS-1.
- coeff_valid  out  1  stream valid.
- coeff_ready  in  1  stream ready.

Behaviour:
- Reset (async, immediate) sets:
  - state IDLE; busy, done, avm_read, coeff_valid = 0; avm_address, coeff_data, coeff_index = 0.
  - All counters and FIFO pointers = 0.
- Reset mid-fetch abandons the fetch. Any avm_readdatavalid arriving after reset with zero reads in flight is dropped.
- State IDLE:
  - get_coeffs=1 latches layer into layer_q, clears issue_cnt, rsp_cnt and out_cnt, and moves to ISSUE. busy=1 from the next cycle.
  - get_coeffs while not IDLE is ignored; layer changes outside the start cycle are ignored.
- State ISSUE:
  - avm_read=1 when issue_cnt < NUM_COEFFS and credits > 0, where credits = MAX_PENDING − (in_flight + fifo_count).
  - avm_address = COEFF_BASE + layer_q*LAYER_SPAN + issue_cnt, truncated to ADDR_W (wraps modulo 2^ADDR_W).
  - While avm_waitrequest=1, avm_read and avm_address are held stable.
  - A read is accepted when avm_read & !avm_waitrequest: issue_cnt++ and in_flight++.
  - avm_read may stay high back-to-back if credits remain after the acceptance.
  - When issue_cnt reaches NUM_COEFFS, avm_read drops and the state moves to DRAIN.
- Response path:
  - avm_readdatavalid with in_flight > 0 pushes avm_readdata into the FIFO; in_flight-- and rsp_cnt++.
  - The credit rule guarantees the FIFO never overflows; a full-FIFO push is a design error, flagged by assertion.
- Output:
  - coeff_valid = FIFO not empty; coeff_data = FIFO head; coeff_index = out_cnt.
  - A pop occurs when coeff_valid & coeff_ready; out_cnt++.
  - Push and pop in the same cycle leave fifo_count unchanged; an empty FIFO with a push presents data the next cycle (one-cycle latency, no bypass).
  - coeff_data and coeff_index hold stable while coeff_valid=1 and coeff_ready=0.
  - An acceptance, response and pop may all coincide in one cycle; all counters update correctly.
- State DRAIN: when out_cnt reaches NUM_COEFFS, move to DONE.
- State DONE (one cycle): done=1, busy=0, return to IDLE. A get_coeffs in this cycle is ignored; one in the following IDLE cycle is accepted.
- Best case, no waitrequest and 1-cycle read latency, always ready: first coeff_valid 3 cycles after get_coeffs.

Optional Feature:
- Macro: COEFF_FETCH_CHECKSUM_EN.
- When defined:
  - Adds output checksum[15:0], the modular sum of all coefficients popped in the current fetch.
  - Cleared on start; valid and stable from the done cycle until the next start; 0 after reset.
- When undefined: the port and its adder do not exist; all other behaviour is identical.

Test Plan:
- Layer 0, slave returns addr-low-byte, no stalls, ready=1 -> reads at 0x040..0x048; stream indexes 0..8 with data 0x40..0x48; single done pulse; busy low after.
- Layer 2 -> first address 0x060, last 0x068; coeff_index restarts at 0.
- coeff_ready=0 throughout -> exactly 4 reads issued, avm_read low until a pop. Releasing ready completes all 9 in order.
- avm_waitrequest high 3 cycles on first read -> address 0x040 and avm_read held for 4 cycles; no duplicate read; data order intact.
- get_coeffs pulsed again mid-fetch with layer=3 -> ignored, still 9 layer-0 coefficients. Reset asserted after 5 pops -> all outputs 0 immediately; stray readdatavalid dropped; new fetch is correct.
- With COEFF_FETCH_CHECKSUM_EN, data 0x40..0x48 -> checksum 0x0264 at done.
